ft245_ctrl: RTL and testbench
=============================

# ft245_ctrl

Sequencer for the FT245 asynchronous FIFO bus between the spectrometer core and the USB host. It converts a byte-stream TX interface (sample data to host) and an RX interface (command bytes from host) into correctly timed RD#/WR strobes on the shared 8-bit bus. It arbitrates between pending reads and writes round-robin. It sits between the core logic and the top-level tristate pad, which is built from ft_d_o/ft_d_oe/ft_d_i.

## Interface
- RD_PULSE, 3: cycles ft_rd_n held low per read (1..255)
- WR_SETUP, 1: cycles data driven before ft_wr rises (1..255)
- WR_PULSE, 2: cycles ft_wr held high per write (1..255)
- GAP, 4: idle cycles after every transaction, all strobes inactive (3..255)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ft_d_i  in  8  bus data from pad
- ft_d_o  out  8  bus data to pad
- ft_d_oe  out  1  pad output enable, 1 = drive bus
- ft_rd_n  out  1  FT245 RD#, active low
- ft_wr  out  1  FT245 WR, active high, data latched by device on falling edge
- ft_txe_n  in  1  FT245 TXE#, low = device can accept a byte (asynchronous)
- ft_rxf_n  in  1  FT245 RXF#, low = device holds a byte (asynchronous)
- tx_data  in  8  byte to send to host
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted this cycle (combinational)
- rx_data  out  8  byte received from host
- rx_valid  out  1  rx_data valid, held until consumed
- rx_ready  in  1  consumer takes rx_data when rx_valid & rx_ready
- busy  out  1  state != IDLE

## Operation
- ft_txe_n, ft_rxf_n each pass through a 2-flop synchronizer; both sync flops reset to 1 (inactive).
- States: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, GAP. One 8-bit down-counter times every state.
- Eligibility in IDLE: rd_ok = rxf_sync==0 & rx_valid==0; wr_ok = txe_sync==0 & tx_valid==1.
- Grant: only one eligible -> that one; both -> the opposite of last_served; last_served resets to WRITE, so the first contested grant goes to read. last_served updates on every grant.
- tx_ready = IDLE & write granted; the tx_data byte is captured into the output register on that edge.
- Read: IDLE -> RD_STROBE (RD_PULSE cycles) -> GAP.
- Write: IDLE -> WR_SETUP (WR_SETUP cycles) -> WR_STROBE (WR_PULSE cycles) -> WR_HOLD (1 cycle) -> GAP.
- GAP (GAP cycles) -> IDLE. GAP ≥ 3 guarantees the synchronized flags reflect the device's post-strobe flag update before the next decision.
- rx_valid clears on the edge where rx_valid & rx_ready. A new read is never started while rx_valid=1 (no overrun, no drop).
- Reset at any point: every output goes to its reset value immediately. An in-flight strobe is truncated. Counter and last_served are reinitialised.

## Timing
- Reset values: ft_rd_n=1, ft_wr=0, ft_d_oe=0, ft_d_o=0, rx_valid=0, rx_data=0, busy=0. tx_ready=0 (flags are inactive).
- All bus outputs are registered; no combinational path from any input to ft_rd_n/ft_wr/ft_d_oe/ft_d_o.
- Flag-to-grant latency: 2 cycles of synchronizer plus the IDLE decision edge.
- Read, decision at edge E0:
  - ft_rd_n low from E0 through E0+RD_PULSE.
  - ft_d_i is sampled into rx_data on edge E0+RD_PULSE, the same edge that returns ft_rd_n high.
  - rx_valid=1 from that edge.
- Write, decision at edge E0:
  - ft_d_oe=1 and ft_d_o=byte from E0.
  - ft_wr high from E0+WR_SETUP to E0+WR_SETUP+WR_PULSE.
  - Data and ft_d_oe held one further cycle, then ft_d_oe=0 at E0+WR_SETUP+WR_PULSE+1.
- ft_d_oe and ft_rd_n low are never asserted in the same cycle.
- Transaction period: read = RD_PULSE+GAP+1 cycles; write = WR_SETUP+WR_PULSE+1+GAP+1 cycles (defaults: 8 and 9).
- Flags changing during a strobe or GAP are ignored until IDLE.

## Test plan
- Reset then single write:
  - Stimulus: ft_txe_n=0, tx_valid=1, tx_data=0x55.
  - Response: tx_ready pulses 1 cycle (3rd cycle after release). ft_d_oe=1 with ft_d_o=0x55 for 4 cycles. ft_wr high cycles 2-3 of that window. busy low again after 9 cycles.
- Single read:
  - Stimulus: ft_rxf_n=0, ft_d_i=0xA7, rx_ready=0.
  - Response: ft_rd_n low exactly 3 cycles. rx_data=0xA7 and rx_valid=1 on the rising edge of ft_rd_n. No second read while rx_valid=1. rx_ready=1 for one cycle clears rx_valid, and the next read follows.
- Contention:
  - Stimulus: ft_txe_n=0, ft_rxf_n=0, tx_valid=1 continuously, rx_ready=1.
  - Response: strict alternation RD, WR, RD, WR.... ft_d_oe and ft_rd_n never both active.
- Flags inactive:
  - Stimulus: ft_txe_n=1 with tx_valid=1; ft_rxf_n=1.
  - Response: busy stays 0, tx_ready stays 0, strobes idle.
- Async reset:
  - Stimulus: rst_n pulsed low mid WR_STROBE, and separately mid RD_STROBE.
  - Response: ft_wr=0, ft_d_oe=0, ft_rd_n=1 with no clock edge. After release, the first contested grant is a read.
- Parameter override:
  - Stimulus: RD_PULSE=5, WR_PULSE=4, GAP=3.
  - Response: measured strobe widths of 5 and 4 cycles, and 3 idle cycles between transactions.

Source files
------------

// File: rtl/ft245_ctrl.sv
// rtl/ft245_ctrl.sv - FT245 async FIFO bus sequencer with round-robin read/write arbitration.
// All bus-facing outputs come straight from flops; device flags are double-synchronized.
module ft245_ctrl #(
  parameter int RD_PULSE = 3,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int GAP      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ft_d_i,
  output logic [7:0] ft_d_o,
  output logic       ft_d_oe,
  output logic       ft_rd_n,
  output logic       ft_wr,
  input  logic       ft_txe_n,
  input  logic       ft_rxf_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_STROBE = 3'd1;
  localparam logic [2:0] S_WR_SETUP  = 3'd2;
  localparam logic [2:0] S_WR_STROBE = 3'd3;
  localparam logic [2:0] S_WR_HOLD   = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;

  localparam logic [7:0] RD_LOAD  = 8'(RD_PULSE - 1);
  localparam logic [7:0] WS_LOAD  = 8'(WR_SETUP - 1);
  localparam logic [7:0] WP_LOAD  = 8'(WR_PULSE - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       txe_meta_q, txe_meta_d, txe_sync_q, txe_sync_d;
  logic       rxf_meta_q, rxf_meta_d, rxf_sync_q, rxf_sync_d;
  logic       last_wr_q, last_wr_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  logic rd_ok, wr_ok, grant_rd, grant_wr, idle;

  assign idle  = (state_q == S_IDLE);
  assign rd_ok = !rxf_sync_q && !rx_valid_q;
  assign wr_ok = !txe_sync_q && tx_valid;
  // On contention, serve whichever direction did not go last.
  assign grant_rd = rd_ok && (!wr_ok || last_wr_q);
  assign grant_wr = wr_ok && (!rd_ok || !last_wr_q);

  assign tx_ready = idle && grant_wr;
  assign busy     = !idle;
  assign ft_d_o   = dout_q;
  assign ft_d_oe  = oe_q;
  assign ft_rd_n  = rd_n_q;
  assign ft_wr    = wr_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    txe_meta_d = ft_txe_n;
    txe_sync_d = txe_meta_q;
    rxf_meta_d = ft_rxf_n;
    rxf_sync_d = rxf_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    rd_n_d     = rd_n_q;
    wr_d       = wr_q;
    oe_d       = oe_q;
    dout_d     = dout_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_rd) begin
          state_d   = S_RD_STROBE;
          cnt_d     = RD_LOAD;
          rd_n_d    = 1'b0;
          last_wr_d = 1'b0;
        end else if (grant_wr) begin
          state_d   = S_WR_SETUP;
          cnt_d     = WS_LOAD;
          oe_d      = 1'b1;
          dout_d    = tx_data;
          last_wr_d = 1'b1;
        end
      end
      S_RD_STROBE: begin
        if (cnt_q == 8'd0) begin
          // Sample on the same edge that releases RD#, while the device still drives.
          rd_n_d     = 1'b1;
          rx_data_d  = ft_d_i;
          rx_valid_d = 1'b1;
          state_d    = S_GAP;
          cnt_d      = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WR_SETUP: begin
        if (cnt_q == 8'd0) begin
          wr_d    = 1'b1;
          state_d = S_WR_STROBE;
          cnt_d   = WP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WR_STROBE: begin
        if (cnt_q == 8'd0) begin
          wr_d    = 1'b0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WR_HOLD: begin
        oe_d    = 1'b0;
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        rd_n_d  = 1'b1;
        wr_d    = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      txe_meta_q <= 1'b1;
      txe_sync_q <= 1'b1;
      rxf_meta_q <= 1'b1;
      rxf_sync_q <= 1'b1;
      last_wr_q  <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_q       <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txe_meta_q <= txe_meta_d;
      txe_sync_q <= txe_sync_d;
      rxf_meta_q <= rxf_meta_d;
      rxf_sync_q <= rxf_sync_d;
      last_wr_q  <= last_wr_d;
      rd_n_q     <= rd_n_d;
      wr_q       <= wr_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_ft245_ctrl.sv
// tb/tb_ft245_ctrl.sv - vector table, directed corner cases and a randomized FT245 device model.
module tb_ft245_ctrl;

  localparam int RD_PULSE = 3;
  localparam int WR_SETUP = 1;
  localparam int WR_PULSE = 2;
  localparam int GAP      = 4;
  localparam int NROWS    = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ft_d_i, ft_d_o, tx_data, rx_data;
  logic       ft_d_oe, ft_rd_n, ft_wr, ft_txe_n, ft_rxf_n;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, busy;

  logic       rst2_n;
  logic [7:0] ft_d_i2, ft_d_o2, tx_data2, rx_data2;
  logic       ft_d_oe2, ft_rd_n2, ft_wr2, ft_txe_n2, ft_rxf_n2;
  logic       tx_valid2, tx_ready2, rx_valid2, rx_ready2, busy2;

  always #5 clk = ~clk;

  ft245_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ft_d_i(ft_d_i), .ft_d_o(ft_d_o), .ft_d_oe(ft_d_oe),
    .ft_rd_n(ft_rd_n), .ft_wr(ft_wr), .ft_txe_n(ft_txe_n), .ft_rxf_n(ft_rxf_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy)
  );

  ft245_ctrl #(.RD_PULSE(5), .WR_SETUP(1), .WR_PULSE(4), .GAP(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .ft_d_i(ft_d_i2), .ft_d_o(ft_d_o2), .ft_d_oe(ft_d_oe2),
    .ft_rd_n(ft_rd_n2), .ft_wr(ft_wr2), .ft_txe_n(ft_txe_n2), .ft_rxf_n(ft_rxf_n2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .rx_ready(rx_ready2), .busy(busy2)
  );

  typedef struct {
    logic       txe_n, rxf_n, tx_valid, rx_ready;
    logic [7:0] tx_data, d_i;
    logic       e_tx_ready, e_oe, e_wr, e_rd_n, e_busy, e_rxv;
    logic [7:0] e_d_o, e_rxd;
  } vec_t;

  vec_t vecs [NROWS];

  int n_tests = 0;
  int n_fail  = 0;

  logic       prev_rd_n, prev_wr, prev_oe, seen_txn;
  int         rd_run, wr_run, oe_run, idle_run;
  int         log_q[$];
  logic       dev_mode = 1'b0;
  logic       gen = 1'b0;
  logic       tx_fire = 1'b0;
  logic [7:0] host_q[$], host_all[$], exp_wr[$];
  int         rx_idx, dev_cnt, wr_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: observe bus at the falling edge, act as the device, then record handshakes.
  task automatic cyc();
    logic [7:0] b;
    @(negedge clk);
    if (!rst_n) begin
      prev_rd_n = 1'b1; prev_wr = 1'b0; prev_oe = 1'b0; seen_txn = 1'b0;
      rd_run = 0; wr_run = 0; oe_run = 0; idle_run = 0;
    end else begin
      check("rd_oe_overlap", ft_d_oe && !ft_rd_n, 0);
      if (!ft_rd_n && prev_rd_n) begin
        log_q.push_back(0);
        if (seen_txn) check("gap_before_rd", idle_run >= GAP + 1, 1);
        seen_txn = 1'b1;
        if (dev_mode) check("rd_from_empty", host_q.size() > 0, 1);
      end
      if (ft_d_oe && !prev_oe) begin
        log_q.push_back(1);
        if (seen_txn) check("gap_before_wr", idle_run >= GAP + 1, 1);
        seen_txn = 1'b1;
      end
      if (!ft_rd_n) rd_run++;
      else if (!prev_rd_n) begin
        check("rd_width", rd_run, RD_PULSE);
        rd_run = 0;
        if (dev_mode && host_q.size() > 0) void'(host_q.pop_front());
      end
      if (ft_wr) wr_run++;
      else if (prev_wr) begin
        check("wr_width", wr_run, WR_PULSE);
        wr_run = 0;
        if (dev_mode) begin
          wr_seen++;
          check("dev_overflow", dev_cnt < 3, 1);
          dev_cnt++;
          check("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) check("wr_byte", ft_d_o, exp_wr.pop_front());
        end
      end
      if (ft_d_oe) oe_run++;
      else if (prev_oe) begin
        check("oe_width", oe_run, WR_SETUP + WR_PULSE + 1);
        oe_run = 0;
      end
      if (ft_rd_n && !ft_wr && !ft_d_oe) idle_run++;
      else idle_run = 0;
      prev_rd_n = ft_rd_n; prev_wr = ft_wr; prev_oe = ft_d_oe;
    end
    if (dev_mode) begin
      if (dev_cnt > 0 && $urandom_range(5) == 0) dev_cnt--;
      if (gen && host_all.size() < 150 && $urandom_range(7) == 0) begin
        b = 8'($urandom);
        host_q.push_back(b);
        host_all.push_back(b);
      end
      ft_rxf_n = (host_q.size() == 0);
      ft_d_i   = (host_q.size() > 0) ? host_q[0] : 8'($urandom);
      ft_txe_n = (dev_cnt >= 3);
      if (tx_fire || !tx_valid) begin
        tx_valid = gen && ($urandom_range(1) == 0);
        tx_data  = 8'($urandom);
      end
      tx_fire  = 1'b0;
      rx_ready = ($urandom_range(2) != 0);
    end
    #1;
    if (dev_mode) begin
      if (tx_valid && tx_ready) begin
        exp_wr.push_back(tx_data);
        tx_fire = 1'b1;
      end
      if (rx_valid && rx_ready) begin
        check("rx_in_range", rx_idx < host_all.size(), 1);
        if (rx_idx < host_all.size()) check("rx_byte", rx_data, host_all[rx_idx]);
        rx_idx++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w, g, nrd, nwr, ng;
    for (int i = 0; i < NROWS; i++) begin
      vecs[i].txe_n      = (i < 12) ? 1'b0 : 1'b1;
      vecs[i].rxf_n      = (i < 12) ? 1'b1 : 1'b0;
      vecs[i].tx_valid   = (i <= 2);
      vecs[i].tx_data    = 8'h55;
      vecs[i].d_i        = (i < 26) ? 8'hA7 : 8'h3C;
      vecs[i].rx_ready   = (i == 25);
      vecs[i].e_tx_ready = (i == 1);
      vecs[i].e_oe       = (i >= 2 && i <= 5);
      vecs[i].e_wr       = (i == 3 || i == 4);
      vecs[i].e_rd_n     = !((i >= 14 && i <= 16) || (i >= 26 && i <= 28));
      vecs[i].e_busy     = (i >= 2 && i <= 9) || (i >= 14 && i <= 20) || (i >= 26);
      vecs[i].e_rxv      = (i >= 17 && i <= 24) || (i >= 29);
      vecs[i].e_d_o      = 8'h55;
      vecs[i].e_rxd      = (i < 29) ? 8'hA7 : 8'h3C;
    end

    rst_n = 1'b0; rst2_n = 1'b0;
    ft_txe_n = 1'b0; ft_rxf_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
    ft_d_i = 8'h00; rx_ready = 1'b0;
    ft_txe_n2 = 1'b1; ft_rxf_n2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = 8'h22;
    ft_d_i2 = 8'h11; rx_ready2 = 1'b0;
    cyc(); cyc(); cyc();
    check("rst_rd_n", ft_rd_n, 1);
    check("rst_wr", ft_wr, 0);
    check("rst_oe", ft_d_oe, 0);
    check("rst_d_o", ft_d_o, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);

    for (int i = 0; i < NROWS; i++) begin
      ft_txe_n = vecs[i].txe_n; ft_rxf_n = vecs[i].rxf_n; tx_valid = vecs[i].tx_valid;
      tx_data = vecs[i].tx_data; ft_d_i = vecs[i].d_i; rx_ready = vecs[i].rx_ready;
      if (i == 0) rst_n = 1'b1;
      cyc();
      check($sformatf("row%0d_ctl", i), {tx_ready, ft_d_oe, ft_wr, ft_rd_n, busy, rx_valid},
            {vecs[i].e_tx_ready, vecs[i].e_oe, vecs[i].e_wr, vecs[i].e_rd_n, vecs[i].e_busy, vecs[i].e_rxv});
      if (vecs[i].e_oe) check($sformatf("row%0d_d_o", i), ft_d_o, vecs[i].e_d_o);
      if (vecs[i].e_rxv) check($sformatf("row%0d_rx_data", i), rx_data, vecs[i].e_rxd);
    end

    // Flags inactive: a pending tx byte must not start anything.
    ft_txe_n = 1'b1; ft_rxf_n = 1'b1; tx_valid = 1'b1; rx_ready = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("inactive_idle", {busy, tx_ready, ft_wr, ft_d_oe, ft_rd_n}, 5'b00001);
    end

    // Async reset in the middle of a write strobe.
    rx_ready = 1'b0; ft_txe_n = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (ft_wr) break;
    end
    check("wr_reached", ft_wr, 1);
    rst_n = 1'b0;
    #1;
    check("arst_wr", ft_wr, 0);
    check("arst_wr_oe", ft_d_oe, 0);
    check("arst_wr_busy", busy, 0);
    cyc(); cyc();

    // Async reset in the middle of a read strobe.
    ft_txe_n = 1'b1; tx_valid = 1'b0; ft_rxf_n = 1'b0; ft_d_i = 8'h5A;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (!ft_rd_n) break;
    end
    check("rd_reached", ft_rd_n, 0);
    rst_n = 1'b0;
    #1;
    check("arst_rd_n", ft_rd_n, 1);
    check("arst_rd_rxv", rx_valid, 0);
    check("arst_rd_busy", busy, 0);
    cyc(); cyc();

    // Contention after reset: read first, then strict alternation.
    ft_txe_n = 1'b0; ft_rxf_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3; rx_ready = 1'b1;
    log_q.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) cyc();
    check("cont_count", log_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) check($sformatf("cont_order%0d", i), log_q[i], i % 2);

    // Randomized traffic against the device model and scoreboard.
    rst_n = 1'b0;
    tx_valid = 1'b0;
    cyc(); cyc();
    host_q.delete(); host_all.delete(); exp_wr.delete();
    for (int i = 0; i < 5; i++) begin
      host_q.push_back(8'(i * 37 + 1));
      host_all.push_back(8'(i * 37 + 1));
    end
    rx_idx = 0; dev_cnt = 0; wr_seen = 0; tx_fire = 1'b0;
    ft_rxf_n = 1'b0; ft_d_i = host_q[0]; ft_txe_n = 1'b0;
    dev_mode = 1'b1; gen = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) cyc();
    gen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      cyc();
      if (exp_wr.size() == 0 && !tx_valid && host_q.size() == 0 &&
          rx_idx == host_all.size() && !busy) break;
    end
    check("drain_wr", exp_wr.size(), 0);
    check("drain_host", host_q.size(), 0);
    check("drain_rx", rx_idx, host_all.size());
    check("rand_writes_seen", wr_seen > 20, 1);
    check("rand_reads_seen", rx_idx > 20, 1);
    dev_mode = 1'b0;

    // Overridden timing: RD_PULSE=5, WR_PULSE=4, GAP=3 under contention.
    ft_txe_n2 = 1'b0; ft_rxf_n2 = 1'b0; tx_valid2 = 1'b1; rx_ready2 = 1'b1;
    @(negedge clk);
    rst2_n = 1'b1;
    r = 0; w = 0; g = 0; nrd = 0; nwr = 0; ng = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!ft_rd_n2) r++;
      else if (r > 0) begin check("ovr_rd_width", r, 5); r = 0; nrd++; end
      if (ft_wr2) w++;
      else if (w > 0) begin check("ovr_wr_width", w, 4); w = 0; nwr++; end
      if (busy2 && ft_rd_n2 && !ft_wr2 && !ft_d_oe2) g++;
      else if (g > 0) begin check("ovr_gap", g, 3); g = 0; ng++; end
    end
    check("ovr_reads", nrd >= 2, 1);
    check("ovr_writes", nwr >= 2, 1);
    check("ovr_gaps", ng >= 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
